// File: rtl/icache_miss_seq_lv1_il_if.sv
// CPU / tag-array / L2 / LRU signal bundle for the L1 instruction-cache miss sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface icache_miss_seq_lv1_il_if #(
  parameter int ADDR_WID  = 32,
  parameter int ASSOC_WID = 2,
  parameter int CNT_WID   = 16
);
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1;
  logic                 tag_hit;
  logic [ASSOC_WID-1:0] hit_way;
  logic [ASSOC_WID-1:0] lru_replacement_proc;
  logic                 data_in_bus_lv1_lv2;
  logic                 lv2_rd;
  logic [ADDR_WID-1:0]  addr_bus_lv1_lv2;
  logic                 fill_en;
  logic [ASSOC_WID-1:0] fill_way;
  logic                 data_in_bus_cpu_lv1;
  logic                 lru_update;
  logic [ASSOC_WID-1:0] blk_accessed_main;
  logic                 busy;
  logic                 wr_err;
  logic                 lv2_tmo;
  logic [CNT_WID-1:0]   hit_cnt;
  logic [CNT_WID-1:0]   miss_cnt;

  modport master (
    output cpu_rd, cpu_wr, addr_bus_cpu_lv1, tag_hit, hit_way,
           lru_replacement_proc, data_in_bus_lv1_lv2,
    input  lv2_rd, addr_bus_lv1_lv2, fill_en, fill_way, data_in_bus_cpu_lv1,
           lru_update, blk_accessed_main, busy, wr_err, lv2_tmo, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_rd, cpu_wr, addr_bus_cpu_lv1, tag_hit, hit_way,
           lru_replacement_proc, data_in_bus_lv1_lv2,
    output lv2_rd, addr_bus_lv1_lv2, fill_en, fill_way, data_in_bus_cpu_lv1,
           lru_update, blk_accessed_main, busy, wr_err, lv2_tmo, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_miss_seq_lv1_il.sv
// L1 instruction-cache miss sequencer: lookup, L2 line fetch with timeout, fill, CPU acknowledge.
// Outputs are registers or pure state decodes, so no input reaches an output combinationally.
module icache_miss_seq_lv1_il #(
  parameter int ADDR_WID  = 32,
  parameter int ASSOC_WID = 2,
  parameter int CNT_WID   = 16,
  parameter int TMO_CYC   = 255,
  parameter int OFF_WID   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  icache_miss_seq_lv1_il_if.slave    bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] MISS    = 3'd2;
  localparam logic [2:0] FILL    = 3'd3;
  localparam logic [2:0] RESPOND = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [ADDR_WID-1:0] LINE_MASK = ~ADDR_WID'((64'd1 << OFF_WID) - 64'd1);

  logic [2:0]           state;
  logic [ADDR_WID-1:0]  addr_q;
  logic [ASSOC_WID-1:0] way_q;
  logic [TW-1:0]        wait_cnt;
  logic                 abort_q;
  logic                 wr_err_q;
  logic                 tmo_q;
  logic [CNT_WID-1:0]   hit_q;
  logic [CNT_WID-1:0]   miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      way_q    <= '0;
      wait_cnt <= '0;
      abort_q  <= 1'b0;
      wr_err_q <= 1'b0;
      tmo_q    <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      wr_err_q <= 1'b0;
      tmo_q    <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          abort_q  <= 1'b0;
          if (bus.cpu_wr) wr_err_q <= 1'b1;
          if (bus.cpu_rd) begin
            addr_q <= bus.addr_bus_cpu_lv1;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!bus.cpu_rd) begin
            state <= IDLE;
          end else if (bus.tag_hit) begin
            way_q <= bus.hit_way;
            if (!(&hit_q)) hit_q <= hit_q + 1'b1;
            state <= RESPOND;
          end else begin
            way_q <= bus.lru_replacement_proc;
            if (!(&miss_q)) miss_q <= miss_q + 1'b1;
            state <= MISS;
          end
        end
        MISS: begin
          // The L2 request cannot be cancelled; a dropped cpu_rd only suppresses the acknowledge.
          if (!bus.cpu_rd) abort_q <= 1'b1;
          if (bus.data_in_bus_lv1_lv2) begin
            state <= FILL;
          end else if (wait_cnt == TMO_LAST) begin
            tmo_q <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FILL:    state <= (abort_q || !bus.cpu_rd) ? IDLE : RESPOND;
        RESPOND: state <= RELEASE;
        RELEASE: if (!bus.cpu_rd) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lv2_rd              = (state == MISS);
  assign bus.addr_bus_lv1_lv2    = (state == MISS) ? (addr_q & LINE_MASK) : '0;
  assign bus.fill_en             = (state == FILL);
  assign bus.fill_way            = (state == FILL) ? way_q : '0;
  assign bus.data_in_bus_cpu_lv1 = (state == RESPOND);
  assign bus.lru_update          = (state == RESPOND);
  assign bus.blk_accessed_main   = (state == RESPOND) ? way_q : '0;
  assign bus.busy                = (state != IDLE);
  assign bus.wr_err              = wr_err_q;
  assign bus.lv2_tmo             = tmo_q;
  assign bus.hit_cnt             = hit_q;
  assign bus.miss_cnt            = miss_q;
endmodule

// File: tb/tb_icache_miss_seq_lv1_il.sv
// Directed table-driven bench for the instruction-cache miss sequencer, plus multi-cycle corner sequences.
module tb_icache_miss_seq_lv1_il;
  localparam int AW  = 32;
  localparam int WW  = 2;
  localparam int CW  = 4;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int resp_seen = 0;
  int fill_seen = 0;

  icache_miss_seq_lv1_il_if #(.ADDR_WID(AW), .ASSOC_WID(WW), .CNT_WID(CW)) bus ();

  icache_miss_seq_lv1_il #(
    .ADDR_WID(AW), .ASSOC_WID(WW), .CNT_WID(CW), .TMO_CYC(TMO), .OFF_WID(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  hway;
    logic [1:0]  lru;
    logic        l2;
    logic [50:0] exp;
  } vec_t;

  vec_t vecs[24];

  // expected: busy, lv2_rd, l2 addr, fill_en, fill_way, ack, lru_update, blk, wr_err, lv2_tmo, hit_cnt, miss_cnt
  function automatic logic [50:0] ex(input logic b, input logic l2, input logic [31:0] la,
                                     input logic f, input logic [1:0] fw, input logic ak,
                                     input logic lu, input logic [1:0] bk, input logic we,
                                     input logic tm, input logic [3:0] hc, input logic [3:0] mc);
    return {b, l2, la, f, fw, ak, lu, bk, we, tm, hc, mc};
  endfunction

  function automatic logic [50:0] act();
    return {bus.busy, bus.lv2_rd, bus.addr_bus_lv1_lv2, bus.fill_en, bus.fill_way,
            bus.data_in_bus_cpu_lv1, bus.lru_update, bus.blk_accessed_main,
            bus.wr_err, bus.lv2_tmo, bus.hit_cnt, bus.miss_cnt};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.data_in_bus_cpu_lv1 || bus.lru_update) resp_seen++;
    if (bus.fill_en) fill_seen++;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic hit,
                       input logic [1:0] hway, input logic [1:0] lru, input logic l2);
    bus.cpu_rd = rd;
    bus.cpu_wr = wr;
    bus.addr_bus_cpu_lv1 = addr;
    bus.tag_hit = hit;
    bus.hit_way = hway;
    bus.lru_replacement_proc = lru;
    bus.data_in_bus_lv1_lv2 = l2;
  endtask

  task automatic do_hit();
    drive(1'b1, 1'b0, 32'h0000_0100, 1'b1, 2'd0, 2'd0, 1'b0);
    tick(); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick(); tick();
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0);

    // hit at 0x1234, way 2
    vecs[0]  = '{"hit_lookup",   1'b1, 1'b0, 32'h1234, 1'b1, 2'd2, 2'd0, 1'b0, ex(1,0,0,0,0,0,0,0,0,0,0,0)};
    vecs[1]  = '{"hit_resp",     1'b1, 1'b0, 32'h1234, 1'b1, 2'd2, 2'd0, 1'b0, ex(1,0,0,0,0,1,1,2,0,0,1,0)};
    vecs[2]  = '{"hit_release",  1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,0,0,0,0,0,0,0,0,0,1,0)};
    vecs[3]  = '{"hit_idle",     1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,0,0,1,0)};
    // miss at 0x1234, victim way 3, strobe in the 5th MISS cycle
    vecs[4]  = '{"miss_lookup",  1'b1, 1'b0, 32'h1234, 1'b0, 2'd0, 2'd3, 1'b0, ex(1,0,0,0,0,0,0,0,0,0,1,0)};
    vecs[5]  = '{"miss_wait1",   1'b1, 1'b0, 32'h1234, 1'b0, 2'd0, 2'd3, 1'b0, ex(1,1,32'h1230,0,0,0,0,0,0,0,1,1)};
    vecs[6]  = '{"miss_wait2",   1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,1,32'h1230,0,0,0,0,0,0,0,1,1)};
    vecs[7]  = '{"miss_wait3",   1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,1,32'h1230,0,0,0,0,0,0,0,1,1)};
    vecs[8]  = '{"miss_wait4",   1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,1,32'h1230,0,0,0,0,0,0,0,1,1)};
    vecs[9]  = '{"miss_wait5",   1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,1,32'h1230,0,0,0,0,0,0,0,1,1)};
    vecs[10] = '{"miss_fill",    1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b1, ex(1,0,0,1,3,0,0,0,0,0,1,1)};
    vecs[11] = '{"miss_resp",    1'b1, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,0,0,0,0,1,1,3,0,0,1,1)};
    vecs[12] = '{"miss_release", 1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b1, ex(1,0,0,0,0,0,0,0,0,0,1,1)};
    vecs[13] = '{"miss_idle",    1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b1, ex(0,0,0,0,0,0,0,0,0,0,1,1)};
    vecs[14] = '{"l2_ignored",   1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b1, ex(0,0,0,0,0,0,0,0,0,0,1,1)};
    // illegal write alone, then read+write treated as read
    vecs[15] = '{"wr_only",      1'b0, 1'b1, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,1,0,1,1)};
    vecs[16] = '{"wr_clear",     1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,0,0,1,1)};
    vecs[17] = '{"rdwr_lookup",  1'b1, 1'b1, 32'h40,   1'b1, 2'd1, 2'd0, 1'b0, ex(1,0,0,0,0,0,0,0,1,0,1,1)};
    vecs[18] = '{"rdwr_resp",    1'b1, 1'b0, 32'h40,   1'b1, 2'd1, 2'd0, 1'b0, ex(1,0,0,0,0,1,1,1,0,0,2,1)};
    vecs[19] = '{"rdwr_release", 1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(1,0,0,0,0,0,0,0,0,0,2,1)};
    vecs[20] = '{"rdwr_idle",    1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,0,0,2,1)};
    // cpu_rd dropped in LOOKUP: no count, no LRU update
    vecs[21] = '{"abort_lookup", 1'b1, 1'b0, 32'h80,   1'b0, 2'd0, 2'd0, 1'b0, ex(1,0,0,0,0,0,0,0,0,0,2,1)};
    vecs[22] = '{"abort_idle",   1'b0, 1'b0, 32'h0,    1'b1, 2'd2, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,0,0,2,1)};
    vecs[23] = '{"abort_stay",   1'b0, 1'b0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, ex(0,0,0,0,0,0,0,0,0,0,2,1)};

    #12;
    chk("reset_outputs", 64'(act()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].hit, vecs[i].hway, vecs[i].lru, vecs[i].l2);
      tick();
      chk(vecs[i].nm, 64'(act()), 64'(vecs[i].exp));
    end

    // cpu_rd dropped during MISS: fill still happens, no acknowledge or LRU update
    resp_seen = 0;
    drive(1'b1, 1'b0, 32'h2000, 1'b0, 2'd0, 2'd1, 1'b0);
    tick(); tick();
    chk("abort_miss_lv2rd", 64'(bus.lv2_rd), 64'd1);
    chk("abort_miss_cnt", 64'(bus.miss_cnt), 64'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick(); tick();
    bus.data_in_bus_lv1_lv2 = 1'b1;
    tick();
    chk("abort_fill", 64'({bus.fill_en, bus.fill_way}), 64'({1'b1, 2'd1}));
    bus.data_in_bus_lv1_lv2 = 1'b0;
    tick();
    chk("abort_busy", 64'(bus.busy), 64'd0);
    tick(); tick();
    chk("abort_no_resp", 64'(resp_seen), 64'd0);

    // L2 never answers: timeout after TMO MISS cycles
    resp_seen = 0;
    drive(1'b1, 1'b0, 32'h3000, 1'b0, 2'd0, 2'd0, 1'b0);
    tick(); tick();
    n = 0;
    if (bus.lv2_rd) n = 1;
    while (bus.lv2_rd && n < 400) begin
      tick();
      if (bus.lv2_rd) n++;
    end
    bus.cpu_rd = 1'b0;
    chk("tmo_miss_cycles", 64'(n), 64'(TMO));
    chk("tmo_pulse", 64'({bus.lv2_tmo, bus.busy}), 64'({1'b1, 1'b0}));
    tick();
    chk("tmo_pulse_end", 64'(bus.lv2_tmo), 64'd0);
    chk("tmo_no_ack", 64'(resp_seen), 64'd0);
    chk("tmo_miss_cnt", 64'(bus.miss_cnt), 64'd3);

    // saturation: hit_cnt goes 2 -> 15 and holds
    for (int k = 0; k < 13; k++) do_hit();
    chk("sat_reach", 64'(bus.hit_cnt), 64'd15);
    for (int k = 0; k < 3; k++) do_hit();
    chk("sat_hold", 64'(bus.hit_cnt), 64'd15);
    chk("sat_miss_keep", 64'(bus.miss_cnt), 64'd3);

    // reset in the middle of MISS
    drive(1'b1, 1'b0, 32'h4000, 1'b0, 2'd0, 2'd2, 1'b0);
    tick(); tick();
    chk("rst_pre_lv2rd", 64'(bus.lv2_rd), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_lv2rd", 64'({bus.lv2_rd, bus.busy}), 64'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_seen = 0;
    fill_seen = 0;
    repeat (4) tick();
    chk("rst_no_fill_ack", 64'({fill_seen[7:0], resp_seen[7:0]}), 64'd0);
    chk("rst_counters", 64'({bus.hit_cnt, bus.miss_cnt, bus.busy}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_miss_seq_lv1_il.md
ICACHE_MISS_SEQ_LV1_IL -- requirements
Module: icache_miss_seq_lv1_il

Interface
REQ-001 SHALL have parameters: ADDR_WID, default 32, CPU address width; ASSOC_WID, default 2, encoded way index width; CNT_WID, default 16, statistics counter width; TMO_CYC, default 255, maximum L2 wait cycles.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU instruction fetch request, held until acknowledged.
- cpu_wr  in  1  CPU write; illegal on the instruction cache.
- addr_bus_cpu_lv1  in  ADDR_WID  fetch address.
- tag_hit  in  1  tag-array hit, valid in LOOKUP.
- hit_way  in  ASSOC_WID  hitting way, valid with tag_hit.
- lru_replacement_proc  in  ASSOC_WID  LRU victim way for the current index.
- data_in_bus_lv1_lv2  in  1  L2 line-return strobe.
- lv2_rd  out  1  line read request to L2.
- addr_bus_lv1_lv2  out  ADDR_WID  line address to L2, offset bits zeroed.
- fill_en  out  1  write the returned line into the data/tag arrays.
- fill_way  out  ASSOC_WID  way written by fill_en.
- data_in_bus_cpu_lv1  out  1  fetch-complete acknowledge to the CPU.
- lru_update  out  1  LRU update strobe.
- blk_accessed_main  out  ASSOC_WID  way reported to the LRU block.
- busy  out  1  high whenever the FSM is not in IDLE.
- wr_err  out  1  one-cycle pulse on an illegal write.
- lv2_tmo  out  1  one-cycle pulse on an L2 timeout.
- hit_cnt, miss_cnt  out  CNT_WID each  saturating statistics counters.

Function
REQ-003 SHALL implement FSM states IDLE, LOOKUP, MISS, FILL, RESPOND, RELEASE.
REQ-004 IDLE: on cpu_rd=1, SHALL latch addr_bus_cpu_lv1 into addr_q and go to LOOKUP.
REQ-005 IDLE: cpu_rd=1 and cpu_wr=1 together SHALL be treated as a read, and SHALL pulse wr_err.
REQ-006 cpu_wr=1 with cpu_rd=0 in IDLE SHALL pulse wr_err for one cycle, and the FSM SHALL stay in IDLE.
REQ-007 LOOKUP (1 cycle) on a hit (tag_hit=1):
- latch hit_way into way_q;
- increment hit_cnt;
- go to RESPOND.
REQ-008 LOOKUP on a miss (tag_hit=0):
- latch lru_replacement_proc into way_q;
- increment miss_cnt;
- go to MISS.
REQ-009 MISS behaviour:
- lv2_rd=1 and addr_bus_lv1_lv2=addr_q with offset bits cleared, both held stable;
- wait counter increments each cycle;
- data_in_bus_lv1_lv2=1 -> go to FILL.
REQ-010 MISS timeout: when the wait counter reaches TMO_CYC with no return, SHALL pulse lv2_tmo, drop lv2_rd, and go to IDLE without acknowledging the CPU.
REQ-011 FILL (1 cycle): fill_en=1 and fill_way=way_q; then go to RESPOND.
REQ-012 RESPOND (1 cycle): SHALL assert data_in_bus_cpu_lv1=1, lru_update=1 and blk_accessed_main=way_q; then go to RELEASE.
REQ-013 RELEASE: SHALL wait for cpu_rd=0 before returning to IDLE, so one request gets exactly one acknowledge.
REQ-014 Latency: hit acknowledge SHALL be 2 cycles after cpu_rd is sampled; miss acknowledge SHALL be 2 cycles after the data_in_bus_lv1_lv2 strobe.
REQ-015 Abort: cpu_rd=0 during LOOKUP SHALL return to IDLE with no counter or LRU update.
REQ-016 Abort during MISS: cpu_rd=0 SHALL still complete MISS and FILL (the L2 request is not cancellable), then go to IDLE with no RESPOND and no LRU update.
REQ-017 Counters SHALL saturate at all-ones and never wrap.
REQ-018 data_in_bus_lv1_lv2 outside MISS SHALL be ignored.
REQ-019 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-020 While rst_n=0, asynchronously: FSM=IDLE; every output, addr_q, way_q and the wait counter = 0; hit_cnt=miss_cnt=0.
REQ-021 Reset asserted mid-MISS SHALL drop lv2_rd immediately, and no fill or acknowledge SHALL follow after release.

Verification
REQ-022 Hit:
- stimulus: cpu_rd=1, addr 0x0000_1234, tag_hit=1, hit_way=2;
- response: data_in_bus_cpu_lv1, lru_update and blk_accessed_main=2 two cycles later; hit_cnt=1.
REQ-023 Miss:
- stimulus: tag_hit=0, lru_replacement_proc=3, L2 strobe after 5 cycles;
- response: lv2_rd held 5 cycles with addr_bus_lv1_lv2 = line-aligned 0x0000_1234; fill_en with fill_way=3; acknowledge 2 cycles after the strobe; miss_cnt=1.
REQ-024 Timeout:
- stimulus: no L2 strobe;
- response: lv2_tmo pulses after 255 MISS cycles; FSM returns to IDLE; no data_in_bus_cpu_lv1.
REQ-025 Abort:
- stimulus: cpu_rd dropped in MISS;
- response: fill_en occurs, no acknowledge, no lru_update.
REQ-026 Illegal write / saturation:
- stimulus: cpu_wr alone;
- response: a wr_err pulse and busy stays 0.
- stimulus: 65536 hits;
- response: hit_cnt holds at 0xFFFF.
REQ-027 Reset:
- stimulus: rst_n=0 mid-MISS;
- response: lv2_rd=0 in the same cycle; all counters read 0 after release.
